ccc_lock_reset_sequencer: RTL and testbench



---
 rtl/ccc_lock_reset_sequencer.sv | 124 ++++++++++++
 tb/tb_ccc_lock_reset_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ccc_lock_reset_sequencer.sv
// Synchronises CCC lock into the fabric domain, filters it, then releases per-domain
// resets one stage at a time; any loss of lock (or SOFT_RST) re-asserts them all.
module ccc_lock_reset_sequencer #(
  parameter int LOCK_FILT  = 16,
  parameter int STAGE_DLY  = 64,
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOCK_IN,
  input  logic                  SOFT_RST,
  output logic [NUM_STAGES-1:0] RST_OUT,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [CNT_W-1:0]      LOSS_COUNT,
  output logic [1:0]            STATE
);

  localparam int MAX_CNT = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic                    lost_q, lost_d;
  logic [CNT_W-1:0]        loss_cnt_q, loss_cnt_d;
  logic                    sync1_q, sync1_d;
  logic                    lock_s_q, lock_s_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      rst_q      <= '1;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
      sync1_q    <= 1'b0;
      lock_s_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
      sync1_q    <= sync1_d;
      lock_s_q   <= lock_s_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_d      = rst_q;
    lost_d     = 1'b0;
    loss_cnt_d = loss_cnt_q;
    sync1_d    = LOCK_IN;
    lock_s_d   = sync1_q;

    case (state_q)
      WAIT_LOCK: begin
        rst_d = '1;
        if (lock_s_q) begin
          state_d = FILTER;
          cnt_d   = '0;
        end
      end
      FILTER: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CW'(LOCK_FILT - 1)) begin
          state_d = RELEASE;
          rst_d   = rst_q << 1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // rst_q is a thermometer: shifting in zeros from the bottom releases
        // stages strictly in index order, and all-zero means the last one fell.
        if (rst_q == '0) begin
          state_d = RUN;
        end else if (cnt_q == CW'(STAGE_DLY - 1)) begin
          rst_d = rst_q << 1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Abort overrides any sequencing step; loss wins over SOFT_RST and is counted.
    if ((state_q == RELEASE || state_q == RUN) && (!lock_s_q || SOFT_RST)) begin
      state_d = WAIT_LOCK;
      rst_d   = '1;
      cnt_d   = '0;
      if (!lock_s_q) begin
        lost_d = 1'b1;
        if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end

    ready_d = (state_d == RUN);
  end

  assign RST_OUT    = rst_q;
  assign READY      = ready_q;
  assign LOCK_LOST  = lost_q;
  assign LOSS_COUNT = loss_cnt_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Directed bench: LOCK_FILT=4, STAGE_DLY=3, NUM_STAGES=3, CNT_W=2; edge-by-edge expectations.
module tb_ccc_lock_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset, lock_in, soft_rst;
  logic [2:0] rst_out;
  logic       ready, lock_lost;
  logic [1:0] loss_count;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ccc_lock_reset_sequencer #(
    .LOCK_FILT (4),
    .STAGE_DLY (3),
    .NUM_STAGES(3),
    .CNT_W     (2)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .LOCK_IN   (lock_in),
    .SOFT_RST  (soft_rst),
    .RST_OUT   (rst_out),
    .READY     (ready),
    .LOCK_LOST (lock_lost),
    .LOSS_COUNT(loss_count),
    .STATE     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One active edge, then settle 1 time unit so outputs and inputs are away from it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts right after the edge where STATE became FILTER; runs to RUN.
  task automatic run_seq(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_filt_rst"}, rst_out, 3'b111);
      chk({tag, "_filt_st"}, state, 2'd1);
    end
    tick();
    chk({tag, "_rel0_rst"}, rst_out, 3'b110);
    chk({tag, "_rel0_st"}, state, 2'd2);
    tick(2);
    chk({tag, "_hold1_rst"}, rst_out, 3'b110);
    tick();
    chk({tag, "_rel1_rst"}, rst_out, 3'b100);
    tick(2);
    chk({tag, "_hold2_rst"}, rst_out, 3'b100);
    tick();
    chk({tag, "_rel2_rst"}, rst_out, 3'b000);
    chk({tag, "_rel2_rdy"}, ready, 1'b0);
    chk({tag, "_rel2_st"}, state, 2'd2);
    tick();
    chk({tag, "_run_rdy"}, ready, 1'b1);
    chk({tag, "_run_st"}, state, 2'd3);
    chk({tag, "_run_lost"}, lock_lost, 1'b0);
  endtask

  // LOCK_IN must already be high before the next edge (E0).
  task automatic acquire(input string tag);
    tick(2);
    chk({tag, "_e1_st"}, state, 2'd0);
    tick();
    chk({tag, "_e2_st"}, state, 2'd1);
    run_seq(tag);
  endtask

  // Drops lock from RUN/RELEASE and checks the 3-edge response.
  task automatic drop_lock(input string tag, input logic [1:0] exp_cnt);
    lock_in = 1'b0;
    tick(2);
    chk({tag, "_f1_lost"}, lock_lost, 1'b0);
    tick();
    chk({tag, "_f2_rst"}, rst_out, 3'b111);
    chk({tag, "_f2_rdy"}, ready, 1'b0);
    chk({tag, "_f2_lost"}, lock_lost, 1'b1);
    chk({tag, "_f2_cnt"}, loss_count, exp_cnt);
    chk({tag, "_f2_st"}, state, 2'd0);
    tick();
    chk({tag, "_f3_lost"}, lock_lost, 1'b0);
    chk({tag, "_f3_cnt"}, loss_count, exp_cnt);
  endtask

  initial begin
    reset = 1'b1; lock_in = 1'b0; soft_rst = 1'b0;
    tick(2);
    chk("rst_rst", rst_out, 3'b111);
    chk("rst_rdy", ready, 1'b0);
    chk("rst_lost", lock_lost, 1'b0);
    chk("rst_cnt", loss_count, 2'd0);
    chk("rst_st", state, 2'd0);

    // Filter abort: lock high at E0..E3, low at E4, high again from E5
    reset = 1'b0; lock_in = 1'b1;
    tick(3);
    chk("fab_e2_st", state, 2'd1);
    tick();
    lock_in = 1'b0;
    tick();
    lock_in = 1'b1;
    tick();
    chk("fab_e5_st", state, 2'd1);
    tick();
    chk("fab_e6_st", state, 2'd0);
    chk("fab_e6_rst", rst_out, 3'b111);
    chk("fab_e6_cnt", loss_count, 2'd0);
    chk("fab_e6_lost", lock_lost, 1'b0);
    tick();
    chk("fab_e7_st", state, 2'd1);
    run_seq("fab");

    // Lock loss in RUN, then reacquire with identical timing
    drop_lock("run_loss", 2'd1);
    lock_in = 1'b1;
    acquire("reacq");

    // SOFT_RST in RUN: resequence without pulse or count
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("soft_rst", rst_out, 3'b111);
    chk("soft_rdy", ready, 1'b0);
    chk("soft_lost", lock_lost, 1'b0);
    chk("soft_cnt", loss_count, 2'd1);
    chk("soft_st", state, 2'd0);
    tick();
    chk("soft_s1_st", state, 2'd1);

    // Loss mid-RELEASE with RST_OUT=100
    tick(4);
    chk("mid_s5_rst", rst_out, 3'b110);
    tick(3);
    chk("mid_s8_rst", rst_out, 3'b100);
    drop_lock("mid_loss", 2'd2);

    // Simultaneous loss and SOFT_RST: loss wins and is counted
    lock_in = 1'b1;
    acquire("acq3");
    lock_in = 1'b0;
    tick(2);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("both_rst", rst_out, 3'b111);
    chk("both_lost", lock_lost, 1'b1);
    chk("both_cnt", loss_count, 2'd3);
    tick();
    chk("both_lost_off", lock_lost, 1'b0);

    // RESET mid-RELEASE
    lock_in = 1'b1;
    tick(3);
    chk("rmid_st", state, 2'd1);
    tick(4);
    chk("rmid_rel", rst_out, 3'b110);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_cnt", loss_count, 2'd0);
    chk("rmid_rst", rst_out, 3'b111);
    chk("rmid_st0", state, 2'd0);
    chk("rmid_rdy", ready, 1'b0);

    // Saturation: counts 1,2,3,3,3 with a pulse every time
    for (int i = 0; i < 5; i++) begin
      acquire($sformatf("sat%0d", i));
      drop_lock($sformatf("sat%0d", i), (i < 3) ? 2'(i + 1) : 2'd3);
      lock_in = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
